// File: rtl/data_m_pkg.sv
// rtl/data_m_pkg.sv - shared types and constants for the data_m bus initiator
package data_m_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } data_m_master_state_t;

  typedef struct packed {
    logic [18:0] addr;
    logic [15:0] data;
    logic [1:0]  bytesel;
    logic        wr;
  } data_m_cmd_t;

  localparam logic [15:0] DATA_M_TIMEOUT_DATA = 16'hFFFF;

endpackage

// File: rtl/data_m_master_if.sv
// rtl/data_m_master_if.sv - command/response streams and data_m bus signals
interface data_m_master_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [18:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_bytesel;
  logic        cmd_wr;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_error;

  logic [18:0] data_m_addr;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, cmd_bytesel, cmd_wr,
    input  rsp_ready, data_m_ack, data_m_data_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_error,
    output data_m_addr, data_m_data_out, data_m_bytesel, data_m_wr_en, data_m_access
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, cmd_bytesel, cmd_wr,
    output rsp_ready, data_m_ack, data_m_data_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_error,
    input  data_m_addr, data_m_data_out, data_m_bytesel, data_m_wr_en, data_m_access
  );

endinterface

// File: rtl/AckTimeout.sv
// rtl/AckTimeout.sv - ack wait counter; expired flags the last allowed ACCESS cycle
module AckTimeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts prior ack-less cycles, so the TIMEOUT_CYCLES-th one is the last
  assign expired = run && (cnt_q == LAST_CNT);

endmodule

// File: rtl/data_m_master.sv
// rtl/data_m_master.sv - single-outstanding data_m bus initiator
// Optional ack timeout: define DATA_M_MASTER_TIMEOUT_EN.
module data_m_master
  import data_m_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  data_m_master_if.master   bus
);

  data_m_master_state_t state_q, state_d;
  data_m_cmd_t          cmd_q, cmd_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 access_q, access_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [15:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_error_q, rsp_error_d;
  logic                 handshake;
  logic                 expired;

  assign handshake = bus.cmd_valid && cmd_ready_q;

`ifdef DATA_M_MASTER_TIMEOUT_EN
  logic start;
  logic run;

  assign start = (state_q == IDLE) && handshake && (bus.cmd_bytesel != 2'b00);
  assign run   = (state_q == ACCESS) && !bus.data_m_ack;

  AckTimeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_ack_timeout (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .run     (run),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_ready_d = cmd_ready_q;
    access_d    = access_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (handshake) begin
          cmd_d.addr    = bus.cmd_addr;
          cmd_d.data    = bus.cmd_data;
          cmd_d.bytesel = bus.cmd_bytesel;
          cmd_d.wr      = bus.cmd_wr;
          cmd_ready_d   = 1'b0;
          if (bus.cmd_bytesel != 2'b00) begin
            state_d  = ACCESS;
            access_d = 1'b1;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_error_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        // ack takes priority so a same-cycle timeout still completes normally
        if (bus.data_m_ack) begin
          state_d     = RESP;
          access_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = cmd_q.wr ? 16'h0000 : bus.data_m_data_in;
          rsp_error_d = 1'b0;
        end else if (expired) begin
          state_d     = RESP;
          access_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = DATA_M_TIMEOUT_DATA;
          rsp_error_d = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_ready_q <= 1'b0;
      access_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_ready_q <= cmd_ready_d;
      access_q    <= access_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_error       = rsp_error_q;
  assign bus.data_m_access   = access_q && !bus.data_m_ack;
  assign bus.data_m_wr_en    = bus.data_m_access && cmd_q.wr;
  assign bus.data_m_addr     = cmd_q.addr;
  assign bus.data_m_data_out = cmd_q.data;
  assign bus.data_m_bytesel  = cmd_q.bytesel;

endmodule

// File: tb/tb_data_m_master.sv
// tb/tb_data_m_master.sv - randomized self-checking bench for data_m_master
module tb_data_m_master;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail = 0;

  data_m_master_if bus ();

  data_m_master #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected {error, data} from the command and what the responder returned.
  function automatic logic [16:0] model(input logic [1:0] bsel, input logic wr,
                                        input logic [15:0] rdata, input bit timed_out);
    if (bsel == 2'b00) return {1'b1, 16'h0000};
    if (timed_out)     return {1'b1, 16'hFFFF};
    if (wr)            return {1'b0, 16'h0000};
    return {1'b0, rdata};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_data"},  32'(bus.rsp_data), 0);
    check({tag, "_rsp_error"}, 32'(bus.rsp_error), 0);
    check({tag, "_access"},    32'(bus.data_m_access), 0);
    check({tag, "_wr_en"},     32'(bus.data_m_wr_en), 0);
    check({tag, "_addr"},      32'(bus.data_m_addr), 0);
    check({tag, "_dout"},      32'(bus.data_m_data_out), 0);
    check({tag, "_bytesel"},   32'(bus.data_m_bytesel), 0);
  endtask

  task automatic issue(input logic [18:0] addr, input logic [15:0] data,
                       input logic [1:0] bsel, input logic wr);
    @(negedge clk);
    check("cmd_ready_idle", 32'(bus.cmd_ready), 1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_addr    = addr;
    bus.cmd_data    = data;
    bus.cmd_bytesel = bsel;
    bus.cmd_wr      = wr;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = 19'($urandom);
    bus.cmd_data    = 16'($urandom);
    bus.cmd_bytesel = 2'($urandom);
    bus.cmd_wr      = 1'($urandom);
  endtask

  // lat = ack-less access cycles before the ack cycle; lat 0 = responder never acks.
  task automatic do_cmd(input logic [18:0] addr, input logic [15:0] data,
                        input logic [1:0] bsel, input logic wr, input int lat,
                        input logic [15:0] rdata, input int bp);
    logic [16:0] exp;
    int n_acc;
    issue(addr, data, bsel, wr);
    if (bsel != 2'b00) begin
      n_acc = (lat == 0) ? TO : lat;
      for (int k = 0; k < n_acc; k++) begin
        check("acc_high",    32'(bus.data_m_access), 1);
        check("acc_addr",    32'(bus.data_m_addr), 32'(addr));
        check("acc_dout",    32'(bus.data_m_data_out), 32'(data));
        check("acc_bytesel", 32'(bus.data_m_bytesel), 32'(bsel));
        check("acc_wr_en",   32'(bus.data_m_wr_en), 32'(wr));
        check("acc_no_rsp",  32'(bus.rsp_valid), 0);
        @(negedge clk);
      end
      if (lat != 0) begin
        bus.data_m_ack     = 1'b1;
        bus.data_m_data_in = rdata;
        #1;
        check("ack_acc_low", 32'(bus.data_m_access), 0);
        check("ack_wr_low",  32'(bus.data_m_wr_en), 0);
        @(negedge clk);
        bus.data_m_ack     = 1'b0;
        bus.data_m_data_in = 16'($urandom);
      end
    end
    exp = model(bsel, wr, rdata, lat == 0);
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    check("rsp_data",  32'(bus.rsp_data), 32'(exp[15:0]));
    check("rsp_error", 32'(bus.rsp_error), 32'(exp[16]));
    check("rsp_acc",   32'(bus.data_m_access), 0);
    for (int b = 0; b < bp; b++) begin
      bus.data_m_ack = 1'($urandom);
      @(negedge clk);
      bus.data_m_ack = 1'b0;
      check("bp_valid",     32'(bus.rsp_valid), 1);
      check("bp_data",      32'(bus.rsp_data), 32'(exp[15:0]));
      check("bp_error",     32'(bus.rsp_error), 32'(exp[16]));
      check("bp_cmd_ready", 32'(bus.cmd_ready), 0);
      check("bp_acc",       32'(bus.data_m_access), 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_cmd_ready", 32'(bus.cmd_ready), 1);
    check("post_rsp_valid", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    reset              = 1'b0;
    bus.cmd_valid      = 1'b0;
    bus.cmd_addr       = '0;
    bus.cmd_data       = '0;
    bus.cmd_bytesel    = '0;
    bus.cmd_wr         = 1'b0;
    bus.rsp_ready      = 1'b0;
    bus.data_m_ack     = 1'b0;
    bus.data_m_data_in = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    do_cmd(19'h00020, 16'h0000, 2'b01, 1'b0, 1, 16'h00A5, 0);
    do_cmd(19'h12345, 16'h1234, 2'b11, 1'b1, 5, 16'hBEEF, 0);
    do_cmd(19'h7FFFF, 16'h5555, 2'b10, 1'b0, 2, 16'hC3C3, 10);
    do_cmd(19'h00001, 16'hAAAA, 2'b00, 1'b0, 3, 16'h1111, 2);
    do_cmd(19'h00002, 16'hAAAA, 2'b00, 1'b1, 3, 16'h2222, 0);
`ifdef DATA_M_MASTER_TIMEOUT_EN
    do_cmd(19'h00100, 16'h0000, 2'b11, 1'b0, 0, 16'h0000, 1);
    do_cmd(19'h00104, 16'h0000, 2'b11, 1'b0, TO - 1, 16'h4321, 0);
`endif

    // Reset while an access is in flight.
    issue(19'h0ABCD, 16'h9876, 2'b11, 1'b1);
    check("mid_acc_high", 32'(bus.data_m_access), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b1;
    @(negedge clk);
    check("rel_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rel_acc",       32'(bus.data_m_access), 0);
    do_cmd(19'h00040, 16'h0000, 2'b01, 1'b0, 1, 16'h5A5A, 0);

    for (int i = 0; i < 40; i++) begin
      do_cmd(19'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             $urandom_range(1, TO - 1), 16'($urandom), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_m_master.md
# data_m_master

Bus initiator for the `data_m` peripheral bus: accepts single-access commands over a valid/ready stream, drives one `data_m` access per command, waits for the responder's `data_m_ack`, and returns read data (or a write completion) over a response stream. It sits between a command source (debug UART bridge, boot sequencer) and the existing `data_m` responders (timer, PIC, UART), which register `data_m_ack` one or more cycles after seeing `data_m_access`.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent waiting for `data_m_ack` before aborting. Legal range is 1..65535.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous reset, active-low: the block is held in reset while `reset` = 0.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_addr`  in  19  word address, bits [19:1].
- `cmd_data`  in  16  write data.
- `cmd_bytesel`  in  2  byte enables.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when `rsp_valid & rsp_ready`.
- `rsp_data`  out  16  read data. 0 for writes.
- `rsp_error`  out  1  access aborted or rejected.
- `data_m_addr`  out  19  bits [19:1].
- `data_m_data_out`  out  16  write data.
- `data_m_bytesel`  out  2  byte enables.
- `data_m_wr_en`  out  1  write strobe.
- `data_m_access`  out  1  access request.
- `data_m_ack`  in  1  responder completion.
- `data_m_data_in`  in  16  read data, valid in the `data_m_ack` cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch the command into the address, data, bytesel and wr registers.
  - If `cmd_bytesel` != 0, go to ACCESS.
  - If `cmd_bytesel` == 0, go directly to RESP with `rsp_error` = 1 and `rsp_data` = 0, and perform no bus access.
- ACCESS:
  - `data_m_access` = 1 while `data_m_ack` = 0.
  - `data_m_access` is combinationally forced to 0 in the cycle `data_m_ack` = 1, so the responder never sees a second access.
  - `data_m_wr_en` = latched wr, gated by `data_m_access`.
  - Address, data and bytesel outputs are held stable for the whole state.
  - On `data_m_ack`:
    - Read: capture `data_m_data_in` into `rsp_data` and set `rsp_error` = 0.
    - Write: set `rsp_data` = 0 and `rsp_error` = 0.
    - Go to RESP.
- RESP:
  - `rsp_valid` = 1 and the response is held stable until `rsp_ready`, then go to IDLE.
  - `cmd_ready` = 0 in both ACCESS and RESP, so only one access is outstanding at a time.
- `data_m_ack` seen outside ACCESS is ignored.
- Reset (`reset` = 0) at any point returns the block to IDLE and abandons any in-flight access or response. Output values under reset:
  - `cmd_ready` = 0.
  - `rsp_valid`, `rsp_data`, `rsp_error` = 0.
  - All `data_m_*` outputs = 0.

## Timing
- Command accepted on edge N: `data_m_access` = 1 from cycle N+1.
- `data_m_ack` at cycle A: `rsp_valid` = 1 from cycle A+1.
- Minimum command-to-response latency is 2 cycles plus responder latency. With the 1-cycle-ack timer this is 3 cycles.
- After `rsp_ready` at cycle R: `cmd_ready` = 1 at cycle R+1, so back-to-back commands are spaced at least 4 cycles apart.
- `cmd_ready` is registered state, with no combinational path from `cmd_valid`.
- `rsp_valid` is registered.
- The only combinational input-to-output path is `data_m_ack` -> `data_m_access`/`data_m_wr_en`.

## Configuration
- Macro: `DATA_M_MASTER_TIMEOUT_EN`.
- Defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, drop `data_m_access` and go to RESP with `rsp_error` = 1 and `rsp_data` = 16'hFFFF.
  - An ack arriving in the same cycle as the timeout wins: normal completion.
- Not defined:
  - No counter is built and ACCESS waits indefinitely.
  - `rsp_error` is set only by the `cmd_bytesel` == 0 rejection.

## Structure
- Shared package `data_m_pkg`:
  - `data_m_master_state_t` enum (IDLE, ACCESS, RESP).
  - `data_m_cmd_t` packed struct (addr, data, bytesel, wr).
  - `DATA_M_TIMEOUT_DATA` = 16'hFFFF.
- One sub-module, `AckTimeout`:
  - Ports: `clk`, `reset`, `start`, `run`, `expired`.
  - Parameterised by `TIMEOUT_CYCLES`.
  - Instantiated only under `DATA_M_MASTER_TIMEOUT_EN`.

## Test plan
- **Read:** read at addr 19'h00020 with bytesel 2'b01; responder acks 1 cycle later with 16'h00A5 -> `rsp_data` = 16'h00A5, `rsp_error` = 0, `data_m_access` high for exactly 1 cycle.
- **Write:** write 16'h1234 with bytesel 2'b11; responder acks after 5 cycles -> addr/data/bytesel/`wr_en` stable for all 5 access cycles, `rsp_data` = 0.
- **Response backpressure and back-to-back:** hold `rsp_ready` = 0 for 10 cycles -> `rsp_valid` held, response stable, `cmd_ready` = 0 throughout; two commands issued back-to-back -> exactly two accesses, no duplicate acks consumed.
- **Rejected command:** `cmd_bytesel` = 2'b00 -> no `data_m_access` pulse, response next cycle with `rsp_error` = 1.
- **Timeout:** with `DATA_M_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 8, responder never acks -> access dropped after 8 cycles, `rsp_error` = 1, `rsp_data` = 16'hFFFF. Ack on the 8th cycle -> normal completion.
- **Reset mid-access:** `reset` = 0 during ACCESS -> all outputs 0 next cycle; after release, `cmd_ready` = 1 and a new read completes normally.
